store_merge_rmw: RTL

Store-side counterpart of the load extender in the multicycle datapath. It narrows register data for SB/SH/SW and places it into the correct byte lanes of a 32-bit memory word. Sub-word stores use a read-modify-write sequence on the word-wide data memory. The block sits between the register-file B operand / ALU address output and the data memory port, and is started by the control FSM.

---
 rtl/store_merge_rmw.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/store_merge_rmw.sv
// Store lane merger: narrows SB/SH/SW data into a 32-bit word, using read-modify-write for sub-word stores.
// Build option MEM_BYTE_ENABLE_EN adds mem_be and replaces read-modify-write with byte-enabled writes.
module store_merge_rmw #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        store_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
`ifdef MEM_BYTE_ENABLE_EN
    output logic [3:0]        mem_be,
`endif
    output logic              busy,
    output logic              done,
    output logic              misalign_err
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;
    localparam logic [1:0] ST_XX = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_MERGE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [1:0]         type_q;
    logic [1:0]         off_q;
    logic [15:0]        data_q;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        merged;
    logic               fault;
    logic               accept;

    // Illegal type or misaligned halfword/word; such requests never touch memory
    always_comb begin
        fault = 1'b0;
        if (store_type == ST_XX)
            fault = 1'b1;
        else if (store_type == ST_SH && addr[0])
            fault = 1'b1;
        else if (store_type == ST_SW && addr[1:0] != 2'b00)
            fault = 1'b1;
    end

    assign accept = (state == S_IDLE) && start && !fault;

    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (fault)
                        state_nx = S_DONE;
                    else if (store_type == ST_SW)
                        state_nx = S_WRITE;
                    else
`ifdef MEM_BYTE_ENABLE_EN
                        state_nx = S_WRITE;
`else
                        state_nx = S_READ;
`endif
                end
            end
            S_READ:  state_nx = (MEM_LAT == 1) ? S_MERGE : S_WAIT;
            S_WAIT:  if (cnt == CNT_W'(1)) state_nx = S_MERGE;
            S_MERGE: state_nx = S_WRITE;
            S_WRITE: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Selected lane(s) take the register data, the rest keep the memory word
    always_comb begin
        merged = mem_rdata;
        if (type_q == ST_SB)
            merged[{off_q, 3'b000} +: 8] = data_q[7:0];
        else
            merged[{off_q[1], 4'b0000} +: 16] = data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            misalign_err <= 1'b0;
            type_q       <= ST_SW;
            off_q        <= 2'b00;
            data_q       <= '0;
            cnt          <= '0;
`ifdef MEM_BYTE_ENABLE_EN
            mem_be       <= 4'b0000;
`endif
        end else begin
            mem_rd       <= (state_nx == S_READ);
            mem_wr       <= (state_nx == S_WRITE);
            busy         <= (state_nx != S_IDLE);
            done         <= (state_nx == S_DONE);
            misalign_err <= (state == S_IDLE) && start && fault;

            if (accept) begin
                type_q   <= store_type;
                off_q    <= addr[1:0];
                data_q   <= rs_data[15:0];
                mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                if (store_type == ST_SW)
                    mem_wdata <= rs_data;
`ifdef MEM_BYTE_ENABLE_EN
                else if (store_type == ST_SB)
                    mem_wdata <= {4{rs_data[7:0]}};
                else
                    mem_wdata <= {2{rs_data[15:0]}};
`endif
            end

            if (state_nx == S_READ)
                cnt <= CNT_W'(MEM_LAT - 1);
            else if (state == S_WAIT)
                cnt <= cnt - CNT_W'(1);

            if (state == S_MERGE)
                mem_wdata <= merged;

`ifdef MEM_BYTE_ENABLE_EN
            // Enables live only for the single write cycle that follows acceptance
            if (accept) begin
                if (store_type == ST_SW)
                    mem_be <= 4'b1111;
                else if (store_type == ST_SB)
                    mem_be <= 4'b0001 << addr[1:0];
                else
                    mem_be <= addr[1] ? 4'b1100 : 4'b0011;
            end else begin
                mem_be <= 4'b0000;
            end
`endif
        end
    end

endmodule
